// File: rtl/hour_counter.sv
// Hour stage of a digital clock: counts hours 0..23 from the minute stage's
// carry or from manual increments in set mode. It produces a BCD display in
// 12- or 24-hour format and a one-cycle day carry on a normal-run midnight wrap.
module hour_counter (
  input  logic       clk,
  input  logic       reset_all,
  input  logic       min_carry,
  input  logic       mode_12h,
  input  logic       set_mode,
  input  logic       inc_req,
  output logic [4:0] hour,
  output logic [1:0] disp_tens,
  output logic [3:0] disp_units,
  output logic       pm,
  output logic       day_carry
);

  logic       min_q;
  logic       inc_q;
  logic       mode_q;
  logic       min_rise;
  logic       inc_rise;
  logic       adv;
  logic       wrap_day;
  logic [4:0] hour_next;

  logic [1:0] tens24_d;
  logic [3:0] units24_d;
  logic       tens12_d;
  logic [3:0] units12_d;
  logic       pm12_d;
  logic [4:0] u24_tmp;
  logic [4:0] h12_tmp;
  logic [4:0] u12_tmp;

  logic [1:0] tens24_q;
  logic [3:0] units24_q;
  logic       tens12_q;
  logic [3:0] units12_q;
  logic       pm12_q;
  logic       mode_sel;

  // Edge detection and the single advance decision; set_mode picks the source
  always_comb begin
    min_rise = min_carry & ~min_q;
    inc_rise = inc_req & ~inc_q;
    adv      = (~set_mode & min_rise) | (set_mode & inc_rise);
    wrap_day = ~set_mode & min_rise & (hour == 5'd23);
  end

  // Next hour: out-of-range values recover to 0, otherwise wrap 23 -> 0
  always_comb begin
    hour_next = hour;
    if (hour > 5'd23) begin
      hour_next = 5'd0;
    end else if (adv) begin
      hour_next = (hour == 5'd23) ? 5'd0 : hour + 5'd1;
    end
  end

  // BCD digits for both display formats, derived from the next-state hour
  always_comb begin
    tens24_d  = 2'd0;
    u24_tmp   = hour_next;
    if (hour_next >= 5'd20) begin
      tens24_d = 2'd2;
      u24_tmp  = hour_next - 5'd20;
    end else if (hour_next >= 5'd10) begin
      tens24_d = 2'd1;
      u24_tmp  = hour_next - 5'd10;
    end
    units24_d = u24_tmp[3:0];

    if (hour_next == 5'd0) begin
      h12_tmp = 5'd12;
    end else if (hour_next > 5'd12) begin
      h12_tmp = hour_next - 5'd12;
    end else begin
      h12_tmp = hour_next;
    end
    tens12_d  = (h12_tmp >= 5'd10);
    u12_tmp   = tens12_d ? (h12_tmp - 5'd10) : h12_tmp;
    units12_d = u12_tmp[3:0];
    pm12_d    = (hour_next >= 5'd12);
  end

  // Counter, edge-detect history and day carry; min_q resets high so a carry
  // already held high at reset release does not count as an edge
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      hour      <= 5'd0;
      min_q     <= 1'b1;
      inc_q     <= 1'b0;
      day_carry <= 1'b0;
    end else begin
      hour      <= hour_next;
      min_q     <= min_carry;
      inc_q     <= inc_req;
      day_carry <= wrap_day;
    end
  end

  // Display registers for both formats plus the registered format select
  always_ff @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      tens24_q  <= 2'd0;
      units24_q <= 4'd0;
      tens12_q  <= 1'b1;
      units12_q <= 4'd2;
      pm12_q    <= 1'b0;
      mode_q    <= 1'b0;
    end else begin
      tens24_q  <= tens24_d;
      units24_q <= units24_d;
      tens12_q  <= tens12_d;
      units12_q <= units12_d;
      pm12_q    <= pm12_d;
      mode_q    <= mode_12h;
    end
  end

  // While in reset the live mode input selects the format, so the midnight
  // value of whichever format is requested shows without a clock edge
  always_comb begin
    mode_sel   = reset_all ? mode_q : mode_12h;
    disp_tens  = mode_sel ? {1'b0, tens12_q} : tens24_q;
    disp_units = mode_sel ? units12_q : units24_q;
    pm         = mode_sel & pm12_q;
  end

endmodule

// File: tb/tb_hour_counter.sv
// Scoreboard bench for hour_counter: a behavioural model pushes the expected
// outputs on every clock edge and a monitor pops and compares them, while
// directed scenarios add constant-valued spot checks.
module tb_hour_counter;

  typedef struct packed {
    logic [4:0] hour;
    logic [1:0] tens;
    logic [3:0] units;
    logic       pm;
    logic       dc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_all = 1'b0;
  logic       min_carry = 1'b1;
  logic       mode_12h = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_req = 1'b0;
  logic [4:0] hour;
  logic [1:0] disp_tens;
  logic [3:0] disp_units;
  logic       pm;
  logic       day_carry;

  int   tests_run = 0;
  int   failures  = 0;
  int   dc_count  = 0;
  int   m_hour    = 0;
  bit   m_min_prev = 1'b1;
  bit   m_inc_prev = 1'b0;
  exp_t exp_q[$];

  hour_counter dut (
    .clk        (clk),
    .reset_all  (reset_all),
    .min_carry  (min_carry),
    .mode_12h   (mode_12h),
    .set_mode   (set_mode),
    .inc_req    (inc_req),
    .hour       (hour),
    .disp_tens  (disp_tens),
    .disp_units (disp_units),
    .pm         (pm),
    .day_carry  (day_carry)
  );

  always #5 clk = ~clk;

  // Expected display for an hour, computed from the format rules
  function automatic exp_t make_exp(int h, bit m12, bit dc);
    exp_t e;
    int   d;
    e.hour = h[4:0];
    e.dc   = dc;
    if (m12) begin
      d = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
      e.pm = (h >= 12);
    end else begin
      d = h;
      e.pm = 1'b0;
    end
    e.tens  = 2'(d / 10);
    e.units = 4'(d % 10);
    return e;
  endfunction

  // Reference model: one step per clock edge, cleared by reset
  always @(posedge clk or negedge reset_all) begin
    if (!reset_all) begin
      m_hour     = 0;
      m_min_prev = 1'b1;
      m_inc_prev = 1'b0;
      exp_q.delete();
    end else begin
      bit min_r;
      bit inc_r;
      bit step;
      bit dc;
      min_r = min_carry && !m_min_prev;
      inc_r = inc_req && !m_inc_prev;
      step  = set_mode ? inc_r : min_r;
      dc    = !set_mode && min_r && (m_hour == 23);
      if (step) m_hour = (m_hour + 1) % 24;
      m_min_prev = min_carry;
      m_inc_prev = inc_req;
      exp_q.push_back(make_exp(m_hour, mode_12h, dc));
    end
  end

  // Monitor: every clock with reset released presents one output word
  always @(posedge clk) begin
    #1;
    if (reset_all) begin
      exp_t e;
      exp_t a;
      tests_run++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("[TB] FAIL scoreboard_underflow at %0t: no expected entry", $time);
      end else begin
        e = exp_q.pop_front();
        a = '{hour, disp_tens, disp_units, pm, day_carry};
        if (a !== e) begin
          failures++;
          $display("[TB] FAIL scoreboard at %0t: got hour=%0d tens=%0d units=%0d pm=%0b dc=%0b, expected hour=%0d tens=%0d units=%0d pm=%0b dc=%0b",
                   $time, a.hour, a.tens, a.units, a.pm, a.dc, e.hour, e.tens, e.units, e.pm, e.dc);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests_run++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drive inputs at a falling edge and hold them for n cycles
  task automatic applyStimulus(input bit mc, input bit ir, input bit sm, input bit m12, input int n);
    min_carry = mc;
    inc_req   = ir;
    set_mode  = sm;
    mode_12h  = m12;
    repeat (n) begin
      @(negedge clk);
      if (day_carry) dc_count++;
    end
  endtask

  task automatic minPulse(input bit m12);
    applyStimulus(1'b0, 1'b0, 1'b0, m12, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, m12, 1);
  endtask

  task automatic advanceTo(input int target, input bit m12);
    applyStimulus(1'b1, 1'b0, 1'b0, m12, 1);
    for (int i = 0; i < 30 && m_hour != target; i++) minPulse(m12);
    checkOutput("advance_to", int'(hour), target);
  endtask

  int hours_tbl[5] = '{0, 11, 12, 13, 23};
  int tens_tbl[5]  = '{1, 1, 1, 0, 1};
  int units_tbl[5] = '{2, 1, 2, 1, 1};
  int pm_tbl[5]    = '{0, 0, 1, 1, 1};

  initial begin
    // Reset values in both formats, with the minute carry held high
    repeat (2) @(negedge clk);
    checkOutput("reset_hour", int'(hour), 0);
    checkOutput("reset_tens24", int'(disp_tens), 0);
    checkOutput("reset_units24", int'(disp_units), 0);
    checkOutput("reset_dc", int'(day_carry), 0);
    mode_12h = 1'b1;
    #1;
    checkOutput("reset_tens12", int'(disp_tens), 1);
    checkOutput("reset_units12", int'(disp_units), 2);
    checkOutput("reset_pm12", int'(pm), 0);
    mode_12h = 1'b0;
    @(negedge clk);

    // Release with carry held high: no advance until a fresh edge
    reset_all = 1'b1;
    dc_count  = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4);
    checkOutput("held_carry_hour", int'(hour), 0);
    checkOutput("held_carry_dc", dc_count, 0);
    minPulse(1'b0);
    checkOutput("first_edge_hour", int'(hour), 1);

    // A full day of carries back to 0 with exactly one day carry
    advanceTo(0, 1'b0);
    dc_count = 0;
    for (int i = 0; i < 24; i++) minPulse(1'b0);
    checkOutput("day_hour", int'(hour), 0);
    checkOutput("day_carry_count", dc_count, 1);

    // 12-hour display table
    for (int i = 0; i < 5; i++) begin
      advanceTo(hours_tbl[i], 1'b1);
      checkOutput("disp12_tens", int'(disp_tens), tens_tbl[i]);
      checkOutput("disp12_units", int'(disp_units), units_tbl[i]);
      checkOutput("disp12_pm", int'(pm), pm_tbl[i]);
    end

    // Manual set: three increments from 22 with two discarded minute edges
    advanceTo(22, 1'b0);
    dc_count = 0;
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("set_hour", int'(hour), 1);
    checkOutput("set_dc_count", dc_count, 0);

    // Held increment request advances once
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 10);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 2);
    checkOutput("held_inc_hour", int'(hour), 2);

    // Randomized traffic against the scoreboard
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom), 1'($urandom), ($urandom_range(3) == 0),
                    ($urandom_range(7) == 0) ? ~mode_12h : mode_12h, 1);
    end

    // Asynchronous reset between edges at hour 15
    advanceTo(15, 1'b0);
    @(negedge clk);
    #2;
    reset_all = 1'b0;
    #1;
    checkOutput("async_hour", int'(hour), 0);
    checkOutput("async_tens", int'(disp_tens), 0);
    checkOutput("async_units", int'(disp_units), 0);
    checkOutput("async_pm", int'(pm), 0);
    checkOutput("async_dc", int'(day_carry), 0);
    @(negedge clk);
    #2;
    reset_all = 1'b1;
    dc_count  = 0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 3);
    checkOutput("post_reset_hour", int'(hour), 0);
    minPulse(1'b0);
    checkOutput("post_reset_edge", int'(hour), 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
